// File: rtl/pll_cfg_resp.sv
// pll_cfg_resp -- responder end of the PLL reconfiguration management bus.
//
// Decodes the memtest sequencer's register map into shadow configuration,
// copies shadow to active on a start write, holds an APPLY window, then
// optionally issues a train of phase_step pulses.
//
// Ports:
//   clk, rst_n              single rising-edge clock, async active-low reset
//   mgmt_address/write/     management bus slave (6-bit word address,
//   writedata/read/         32-bit data, combinational readdata,
//   readdata/waitrequest    waitrequest stalls while busy in mode 0)
//   cfg_m/n/c0/c1/k/bw/cp   active configuration words
//   cfg_valid               one-cycle pulse when active words update
//   phase_step/updown/      dynamic-phase interface
//   phase_cnt_sel
//   busy                    high whenever the FSM is not idle
//
// Optional build macro: PLL_CFG_READBACK_EN -- when defined, addresses 3..9
// read back the shadow registers; otherwise only addresses 0 and 1 read.

module pll_cfg_resp #(
  parameter int APPLY_CYCLES = 16,
  parameter int PHASE_GAP    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  mgmt_address,
  input  logic        mgmt_write,
  input  logic [31:0] mgmt_writedata,
  input  logic        mgmt_read,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  output logic [17:0] cfg_m,
  output logic [17:0] cfg_n,
  output logic [17:0] cfg_c0,
  output logic [17:0] cfg_c1,
  output logic [31:0] cfg_k,
  output logic [3:0]  cfg_bw,
  output logic [2:0]  cfg_cp,
  output logic        cfg_valid,
  output logic        phase_step,
  output logic        phase_updown,
  output logic [4:0]  phase_cnt_sel,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_PHASE = 2'd2;

  localparam int CW = (APPLY_CYCLES > 1) ? $clog2(APPLY_CYCLES) : 1;
  localparam int GW = $clog2(PHASE_GAP);

  localparam logic [17:0] N_BYPASS = 18'h10000;

  logic [1:0]    state;
  logic          mode;
  logic [17:0]   sh_n, sh_m, sh_c0, sh_c1;
  logic [31:0]   sh_k;
  logic [3:0]    sh_bw;
  logic [2:0]    sh_cp;
  logic [15:0]   sh_steps;
  logic [4:0]    sh_psel;
  logic          sh_pud;
  logic          phase_pend;
  logic [CW-1:0] apply_cnt;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   remaining;
  logic          wr_en;
  logic          start_wr;
  logic          apply_done;

  assign busy             = (state != ST_IDLE);
  assign mgmt_waitrequest = ~mode & busy & (mgmt_write | mgmt_read);
  // In mode 0 a busy write is stalled by waitrequest; in mode 1 it is dropped.
  // Either way nothing is accepted while busy.
  assign wr_en            = mgmt_write & ~busy;
  assign start_wr         = wr_en && (mgmt_address == 6'd2);
  assign apply_done       = (state == ST_APPLY) && (apply_cnt == '0);
  assign phase_step       = (state == ST_PHASE) && (gap_cnt == '0) && (remaining != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode       <= 1'b0;
      sh_n       <= N_BYPASS;
      sh_m       <= '0;
      sh_c0      <= '0;
      sh_c1      <= '0;
      sh_k       <= '0;
      sh_bw      <= '0;
      sh_cp      <= '0;
      sh_steps   <= '0;
      sh_psel    <= '0;
      sh_pud     <= 1'b0;
      phase_pend <= 1'b0;
    end else begin
      if (wr_en) begin
        case (mgmt_address)
          6'd0: mode <= mgmt_writedata[0];
          6'd3: sh_n <= mgmt_writedata[17:0];
          6'd4: sh_m <= mgmt_writedata[17:0];
          6'd5: begin
            if (mgmt_writedata[22:18] == 5'd0)      sh_c0 <= mgmt_writedata[17:0];
            else if (mgmt_writedata[22:18] == 5'd1) sh_c1 <= mgmt_writedata[17:0];
          end
          6'd6: begin
            sh_steps   <= mgmt_writedata[15:0];
            sh_psel    <= mgmt_writedata[20:16];
            sh_pud     <= mgmt_writedata[21];
            phase_pend <= (mgmt_writedata[15:0] != '0);
          end
          6'd7: sh_k  <= mgmt_writedata;
          6'd8: sh_bw <= mgmt_writedata[3:0];
          6'd9: sh_cp <= mgmt_writedata[2:0];
          default: ;
        endcase
      end
      if (apply_done) phase_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cfg_m         <= '0;
      cfg_n         <= N_BYPASS;
      cfg_c0        <= '0;
      cfg_c1        <= '0;
      cfg_k         <= '0;
      cfg_bw        <= '0;
      cfg_cp        <= '0;
      cfg_valid     <= 1'b0;
      phase_updown  <= 1'b0;
      phase_cnt_sel <= '0;
      apply_cnt     <= '0;
      gap_cnt       <= '0;
      remaining     <= '0;
    end else begin
      cfg_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_wr) begin
            state     <= ST_APPLY;
            cfg_m     <= sh_m;
            cfg_n     <= sh_n;
            cfg_c0    <= sh_c0;
            cfg_c1    <= sh_c1;
            cfg_k     <= sh_k;
            cfg_bw    <= sh_bw;
            cfg_cp    <= sh_cp;
            cfg_valid <= 1'b1;
            apply_cnt <= CW'(APPLY_CYCLES - 1);
          end
        end
        ST_APPLY: begin
          if (apply_cnt == '0) begin
            if (phase_pend) begin
              state         <= ST_PHASE;
              phase_cnt_sel <= sh_psel;
              phase_updown  <= sh_pud;
              remaining     <= sh_steps;
              gap_cnt       <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            apply_cnt <= apply_cnt - 1'b1;
          end
        end
        ST_PHASE: begin
          if (gap_cnt == '0) begin
            if (remaining == '0) begin
              state <= ST_IDLE;
            end else begin
              remaining <= remaining - 1'b1;
              gap_cnt   <= GW'(PHASE_GAP - 1);
            end
          end else begin
            // Leaving one cycle early makes the post-pulse tail exactly
            // PHASE_GAP cycles long, matching the inter-pulse spacing.
            if ((remaining == '0) && (gap_cnt == GW'(1))) state <= ST_IDLE;
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mgmt_readdata = '0;
    case (mgmt_address)
      6'd0: mgmt_readdata = {31'b0, mode};
      6'd1: mgmt_readdata = {31'b0, ~busy};
`ifdef PLL_CFG_READBACK_EN
      6'd3: mgmt_readdata = {14'b0, sh_n};
      6'd4: mgmt_readdata = {14'b0, sh_m};
      6'd5: mgmt_readdata = {14'b0, sh_c0};
      6'd6: mgmt_readdata = {10'b0, sh_pud, sh_psel, sh_steps};
      6'd7: mgmt_readdata = sh_k;
      6'd8: mgmt_readdata = {28'b0, sh_bw};
      6'd9: mgmt_readdata = {29'b0, sh_cp};
`endif
      default: mgmt_readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pll_cfg_resp.sv
// Testbench for pll_cfg_resp: bus-driving tasks plus negedge monitors that
// pop expected apply/phase events from scoreboard queues.

module tb_pll_cfg_resp;

  localparam int APPLY_CYCLES = 16;
  localparam int PHASE_GAP    = 4;
  localparam int LIM          = 500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic [17:0] cfg_m, cfg_n, cfg_c0, cfg_c1;
  logic [31:0] cfg_k;
  logic [3:0]  cfg_bw;
  logic [2:0]  cfg_cp;
  logic        cfg_valid;
  logic        phase_step;
  logic        phase_updown;
  logic [4:0]  phase_cnt_sel;
  logic        busy;

  pll_cfg_resp #(.APPLY_CYCLES(APPLY_CYCLES), .PHASE_GAP(PHASE_GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_read(mgmt_read),
    .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_c0(cfg_c0), .cfg_c1(cfg_c1),
    .cfg_k(cfg_k), .cfg_bw(cfg_bw), .cfg_cp(cfg_cp), .cfg_valid(cfg_valid),
    .phase_step(phase_step), .phase_updown(phase_updown),
    .phase_cnt_sel(phase_cnt_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [17:0] m, n, c0, c1;
    logic [31:0] k;
    logic [3:0]  bw;
    logic [2:0]  cp;
    int          at;
  } cfg_t;

  typedef struct {
    logic [4:0] sel;
    logic       ud;
  } ph_t;

  cfg_t cfg_q[$];
  ph_t  ph_q[$];
  cfg_t ce;
  ph_t  pe;
  int   pulse_cnt  = 0;
  int   last_pulse = 0;
  bit   ph_first   = 1'b0;

  // Shadow-register model.
  logic [17:0] m_n, m_m, m_c0, m_c1;
  logic [31:0] m_k;
  logic [3:0]  m_bw;
  logic [2:0]  m_cp;
  logic        m_pend;
  int          m_steps;
  logic [4:0]  m_sel;
  logic        m_ud;

  task automatic model_reset();
    m_n = 18'h10000; m_m = '0; m_c0 = '0; m_c1 = '0; m_k = '0;
    m_bw = '0; m_cp = '0; m_pend = 1'b0; m_steps = 0; m_sel = '0; m_ud = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cfg_valid) begin
      if (cfg_q.size() == 0) chk("cfg_valid_extra", 32'd1, 32'd0);
      else begin
        ce = cfg_q.pop_front();
        chk("cfg_valid_cyc", cyc, ce.at);
        chk("cfg_m", {14'b0, cfg_m}, {14'b0, ce.m});
        chk("cfg_n", {14'b0, cfg_n}, {14'b0, ce.n});
        chk("cfg_c0", {14'b0, cfg_c0}, {14'b0, ce.c0});
        chk("cfg_c1", {14'b0, cfg_c1}, {14'b0, ce.c1});
        chk("cfg_k", cfg_k, ce.k);
        chk("cfg_bw", {28'b0, cfg_bw}, {28'b0, ce.bw});
        chk("cfg_cp", {29'b0, cfg_cp}, {29'b0, ce.cp});
      end
    end
    if (phase_step) begin
      if (ph_q.size() == 0) chk("phase_step_extra", 32'd1, 32'd0);
      else begin
        pe = ph_q.pop_front();
        chk("phase_sel", {27'b0, phase_cnt_sel}, {27'b0, pe.sel});
        chk("phase_ud", {31'b0, phase_updown}, {31'b0, pe.ud});
        if (!ph_first) chk("phase_gap", cyc - last_pulse, PHASE_GAP);
      end
      ph_first   = 1'b0;
      last_pulse = cyc;
      pulse_cnt++;
    end
  end

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, output int stalls);
    @(negedge clk);
    mgmt_address = a; mgmt_writedata = d; mgmt_write = 1'b1;
    stalls = 0;
    #1;
    while (mgmt_waitrequest && stalls < LIM) begin
      @(negedge clk); #1; stalls++;
    end
    if (stalls >= LIM) chk("bus_wr_timeout", stalls, 0);
    @(posedge clk); #1;
    mgmt_write = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    int stalls;
    @(negedge clk);
    mgmt_address = a; mgmt_read = 1'b1;
    stalls = 0;
    #1;
    while (mgmt_waitrequest && stalls < LIM) begin
      @(negedge clk); #1; stalls++;
    end
    if (stalls >= LIM) chk("bus_rd_timeout", stalls, 0);
    d = mgmt_readdata;
    @(posedge clk); #1;
    mgmt_read = 1'b0;
  endtask

  // Start write; queues the expected apply and phase events from the model.
  task automatic start_apply();
    int s;
    cfg_t e;
    ph_t  p;
    bus_write(6'd2, 32'd0, s);
    e.m = m_m; e.n = m_n; e.c0 = m_c0; e.c1 = m_c1; e.k = m_k;
    e.bw = m_bw; e.cp = m_cp; e.at = cyc;
    cfg_q.push_back(e);
    if (m_pend) begin
      p.sel = m_sel; p.ud = m_ud;
      for (int i = 0; i < m_steps; i++) ph_q.push_back(p);
      ph_first = 1'b1;
      m_pend   = 1'b0;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      if (n >= 4 * LIM) begin
        chk("idle_timeout", n, 0);
        break;
      end
      n++;
    end
  endtask

  initial begin
    int s, n, p0;
    logic [31:0] d;
    rst_n = 1'b0; mgmt_address = '0; mgmt_write = 1'b0;
    mgmt_writedata = '0; mgmt_read = 1'b0;
    model_reset();
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, cfg_valid}, 32'd0);
    chk("rst_step", {31'b0, phase_step}, 32'd0);
    chk("rst_n_word", {14'b0, cfg_n}, 32'h10000);
    chk("rst_m_word", {14'b0, cfg_m}, 32'd0);
    chk("rst_waitreq", {31'b0, mgmt_waitrequest}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(6'd1, d); chk("status_idle", d, 32'd1);
    bus_read(6'd0, d); chk("mode_rst", d, 32'd0);

    // Basic apply.
    bus_write(6'd4, 32'h00808, s);    m_m  = 18'h00808;
    bus_write(6'd7, 32'hB33332DD, s); m_k  = 32'hB33332DD;
    bus_write(6'd3, 32'h10000, s);    m_n  = 18'h10000;
    bus_write(6'd5, 32'h20302, s);    m_c0 = 18'h20302;
    bus_write(6'd5, 32'h60302, s);    m_c1 = 18'h20302;
    bus_write(6'd5, 32'h0C0001, s);   // sel=3: ignored
    bus_write(6'd9, 32'd1, s);        m_cp = 3'd1;
    bus_write(6'd8, 32'd7, s);        m_bw = 4'd7;
    start_apply();
    wait_idle(n);
    chk("apply_busy_len", n, APPLY_CYCLES);
    chk("cfg_q_drained1", cfg_q.size(), 0);

    // Apply followed by a phase sequence.
    bus_write(6'd6, 32'h210005, s);
    m_pend = 1'b1; m_steps = 5; m_sel = 5'd1; m_ud = 1'b1;
    p0 = pulse_cnt;
    start_apply();
    wait_idle(n);
    chk("phase_busy_len", n, APPLY_CYCLES + 5 * PHASE_GAP);
    chk("phase_pulses", pulse_cnt - p0, 5);
    chk("phase_tail", cyc - last_pulse, PHASE_GAP);
    chk("ph_q_drained", ph_q.size(), 0);

    // Mode 0: write while busy is stalled until idle.
    start_apply();
    bus_write(6'd4, 32'h12345, s);
    chk("wr_stalled", (s > 0) ? 32'd1 : 32'd0, 32'd1);
    chk("wr_after_idle", {31'b0, busy}, 32'd0);
    chk("m_not_applied", {14'b0, cfg_m}, 32'h00808);
    m_m = 18'h12345;
    start_apply();
    wait_idle(n);
    chk("apply_busy_len2", n, APPLY_CYCLES);

    // Mode 1: busy writes dropped, status readable.
    bus_write(6'd0, 32'd1, s);
    start_apply();
    bus_write(6'd2, 32'd0, s);
    chk("poll_no_stall", s, 0);
    bus_write(6'd9, 32'd5, s);        // dropped, cp stays 1
    bus_read(6'd1, d); chk("status_busy", d, 32'd0);
    wait_idle(n);
    bus_read(6'd1, d); chk("status_done", d, 32'd1);
    bus_read(6'd0, d); chk("mode_poll", d, 32'd1);
    start_apply();
    wait_idle(n);
    chk("cfg_q_drained2", cfg_q.size(), 0);
    bus_write(6'd0, 32'd0, s);

    // Reset mid-PHASE.
    bus_write(6'd3, 32'h00123, s); m_n = 18'h00123;
    bus_write(6'd6, 32'h3000A, s);
    m_pend = 1'b1; m_steps = 10; m_sel = 5'd3; m_ud = 1'b0;
    p0 = pulse_cnt;
    start_apply();
    n = 0;
    while (pulse_cnt < p0 + 2 && n < LIM) begin
      @(negedge clk); #2; n++;
    end
    chk("pulses_before_rst", pulse_cnt - p0, 2);
    rst_n = 1'b0;
    #1;
    chk("rstp_busy", {31'b0, busy}, 32'd0);
    chk("rstp_step", {31'b0, phase_step}, 32'd0);
    chk("rstp_n_word", {14'b0, cfg_n}, 32'h10000);
    chk("rstp_sel", {27'b0, phase_cnt_sel}, 32'd0);
    ph_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #2;
    chk("no_pulse_after_rst", pulse_cnt - p0, 2);

    // Readback option.
    bus_write(6'd8, 32'hF, s); m_bw = 4'hF;
    bus_read(6'd8, d);
`ifdef PLL_CFG_READBACK_EN
    chk("readback_bw", d, 32'h0000000F);
`else
    chk("readback_bw", d, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_cfg_resp.md
Name: pll_cfg_resp

Overview:
Responder (slave) end of the PLL reconfiguration management bus that the memtest top-level drives when it steps SDRAM clock frequency and phase.
- Decodes the register map the memtest sequencer writes: mode, start, N, M, C, phase, K, bandwidth and charge pump.
- Holds shadow and active configuration, and runs a timed apply sequence, followed by an optional phase-step sequence.
- Stands in for the vendor reconfig IP in simulation, and is reusable as a soft reconfig front-end ahead of a PLL's dynamic-phase pins.

Parameters:
APPLY_CYCLES, 16, cycles the apply state is held (min 1)
PHASE_GAP, 4, cycles between successive phase_step pulses (min 2)

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
mgmt_address  in  6  register address
mgmt_write  in  1  write request
mgmt_writedata  in  32  write data
mgmt_read  in  1  read request
mgmt_readdata  out  32  read data; valid in any cycle where mgmt_read=1 and mgmt_waitrequest=0
mgmt_waitrequest  out  1  stall; holds the master's current access
cfg_m, cfg_n, cfg_c0, cfg_c1  out  18 each  active M/N/C0/C1 counter words
cfg_k  out  32  active fractional K
cfg_bw  out  4  active bandwidth
cfg_cp  out  3  active charge pump
cfg_valid  out  1  one-cycle pulse when active words update
phase_step  out  1  one-cycle pulse per phase step
phase_updown  out  1  direction of the current phase sequence
phase_cnt_sel  out  5  counter targeted by the phase sequence
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; all outputs 0; mgmt_waitrequest=0.
  - Shadow and active registers 0, except shadow/active N=0x10000 (bypass).
  - mode=0; phase_pend=0.
- Register writes (accepted when mgmt_write=1 and mgmt_waitrequest=0):
  - addr0 mode <= wd[0]. 0 = waitrequest mode, 1 = polling mode.
  - addr2 start: any data triggers apply.
  - addr3 N, addr4 M: shadow <= wd[17:0].
  - addr5 C: sel=wd[22:18]. sel=0 sets shadow C0 <= wd[17:0]; sel=1 sets shadow C1; any other sel is ignored.
  - addr6 phase: steps <= wd[15:0], sel <= wd[20:16], updown <= wd[21]; phase_pend <= (wd[15:0]!=0).
  - addr7 K <= wd[31:0]; addr8 BW <= wd[3:0]; addr9 CP <= wd[2:0].
  - Every other address is ignored.
- Reads (combinational mux):
  - addr0 returns {31'b0, mode}; addr1 status returns {31'b0, ~busy}.
  - Any other address returns 0 (see Optional Feature).
- Simultaneous read and write in the same cycle: the write takes effect, and readdata reflects values before that write.
- FSM:
  - IDLE -> APPLY on an accepted start write. Entry cycle: shadow copied to active, cfg_valid=1 for that cycle only, counter <= APPLY_CYCLES-1.
  - APPLY holds until counter=0. Then -> PHASE if phase_pend, otherwise -> IDLE.
  - PHASE entry: latch sel/updown onto phase_cnt_sel/phase_updown, clear phase_pend, remaining <= steps. Pulse phase_step, then wait PHASE_GAP-1 cycles, and repeat until remaining reaches 0. One extra PHASE_GAP cycle follows the last pulse, then -> IDLE.
  - Number of phase_step pulses always equals the steps field exactly. A 0-step write never enters PHASE.
- Waitrequest and busy:
  - mode=0: mgmt_waitrequest = busy & (mgmt_write | mgmt_read); the held access completes in the first IDLE cycle.
  - mode=1: mgmt_waitrequest is never asserted. While busy, writes are dropped; reads still return status.
- Start write while busy: stalled (mode 0) or dropped (mode 1); never re-entrant.
- Shadow writes landing in the same cycle as the start write are not included in that apply.
- Reset asserted mid-APPLY or mid-PHASE: immediate return to IDLE, no further pulses; outputs return to reset values.

Optional Feature:
PLL_CFG_READBACK_EN
- Defined: reads of addr3–9 return the shadow values, zero-extended. addr5 returns {sel=0, C0}; addr6 returns {updown, sel, steps}.
- Undefined: only addr0 and addr1 are readable; all other addresses return 0.

Test Plan:
- Write addr4=0x00808, 7=0xB33332DD, 3=0x10000, 5=0x20302, 5=0x60302, 9=1, 8=7, then 2=0. Expect: cfg_valid pulses once the cycle after the start write; cfg_m=0x00808, cfg_c0=0x20302, cfg_c1=0x20302, cfg_k=0xB33332DD, cfg_cp=1, cfg_bw=7; busy high for exactly 16 cycles.
- After that apply, write addr6=0x210005 then addr2=0. Expect: 16 apply cycles, then exactly 5 phase_step pulses spaced 4 cycles apart, with phase_cnt_sel=1 and phase_updown=1 throughout; busy falls 4 cycles after the 5th pulse.
- mode=0: issue a write to addr4=0x12345 while busy. Expect: mgmt_waitrequest high until IDLE, then the write is accepted; active cfg_m is unchanged until the next start.
- mode=1: issue a write to addr2 during APPLY. Expect: mgmt_waitrequest stays 0, no second cfg_valid pulse; a read of addr1 returns 0 while busy and 1 after.
- Drop rst_n mid-PHASE after 2 pulses. Expect: busy=0, phase_step=0 and N=0x10000 immediately; no further pulses after rst_n rises.
- With PLL_CFG_READBACK_EN defined, write addr8=0xF, then read addr8. Expect: 0x0000000F. With the macro undefined, expect 0.
